codec2_frame_packer: RTL and testbench

//  Downstream stage of the 2400 bit/s Codec2 encoder. Accepts one 48-bit encoded frame per

---
 rtl/codec2_frame_packer_pkg.sv | 28 ++
 rtl/codec2_frame_packer_if.sv | 24 ++
 rtl/codec2_frame_fifo.sv | 55 +++++
 rtl/codec2_frame_packer.sv | 106 ++++++++++
 tb/tb_codec2_frame_packer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/codec2_frame_packer_pkg.sv
// Shared widths, FSM state type and helpers for the Codec2 frame packer.
// Also holds the frame/byte widths used by the encoder top.
package codec2_frame_packer_pkg;

  localparam int unsigned BITS_WIDTH      = 48;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned BYTES_PER_FRAME = BITS_WIDTH / BYTE_W;
  localparam int unsigned FIFO_DEPTH      = 4;
  localparam int unsigned ADDR_W          = 2;
  localparam int unsigned FCNT_W          = ADDR_W + 1;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned IDX_W           = 3;

  typedef logic [BITS_WIDTH-1:0] frame_t;
  typedef logic [BYTE_W-1:0]     byte_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/codec2_frame_packer_if.sv
// Frame push port and byte stream of the packer.
// master = encoder/transport side, slave = packer.
interface codec2_frame_packer_if;
  import codec2_frame_packer_pkg::*;

  frame_t frame_in;
  logic   frame_valid;
  logic   frame_ready;
  byte_t  byte_out;
  logic   byte_valid;
  logic   byte_ready;
  logic   last_byte;

  modport master (
    output frame_in, frame_valid, byte_ready,
    input  frame_ready, byte_out, byte_valid, last_byte
  );

  modport slave (
    input  frame_in, frame_valid, byte_ready,
    output frame_ready, byte_out, byte_valid, last_byte
  );

endinterface

// File: rtl/codec2_frame_fifo.sv
// Synchronous first-word-fall-through frame FIFO; dout shows the head while non-empty.
// Writes while full and reads while empty are ignored.
module codec2_frame_fifo
  import codec2_frame_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  frame_t            din,
  output frame_t            dout,
  output logic [FCNT_W-1:0] count,
  output logic              full,
  output logic              empty
);

  frame_t             mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0]  count_n;
  logic               do_wr;
  logic               do_rd;

  assign full  = (count == FCNT_W'(FIFO_DEPTH));
  assign empty = (count == FCNT_W'(0));
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign dout  = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (do_wr && !do_rd)
      count_n = count + FCNT_W'(1);
    else if (!do_wr && do_rd)
      count_n = count - FCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count_n;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/codec2_frame_packer.sv
// Buffers 48-bit Codec2 frames and serialises each MSB-first as 6 bytes on a
// valid/ready stream, with frame/drop counters and a sticky overflow flag.
module codec2_frame_packer
  import codec2_frame_packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  codec2_frame_packer_if.slave bus,
  input  logic             clear_overflow,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_FRAME - 1);

  state_t             state;
  frame_t             shreg;
  logic [IDX_W-1:0]   byte_idx;
  frame_t             fifo_dout;
  logic [FCNT_W-1:0]  fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               drop;
  logic               pop;
  logic               hand;

  assign bus.frame_ready = (fifo_count != FCNT_W'(FIFO_DEPTH));
  assign push = bus.frame_valid & ~fifo_full;
  assign drop = bus.frame_valid &  fifo_full;
  assign pop  = (state == ST_LOAD);
  assign hand = bus.byte_valid & bus.byte_ready;

  codec2_frame_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (push),
    .rd_en (pop),
    .din   (bus.frame_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Serialiser FSM; byte_out/last_byte only change on a handshake or a load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      shreg          <= '0;
      byte_idx       <= '0;
      bus.byte_out   <= '0;
      bus.byte_valid <= 1'b0;
      bus.last_byte  <= 1'b0;
      frame_count    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.byte_valid <= 1'b0;
          if (!fifo_empty) state <= ST_LOAD;
        end
        ST_LOAD: begin
          shreg          <= fifo_dout;
          byte_idx       <= '0;
          bus.byte_out   <= fifo_dout[BITS_WIDTH-1 -: BYTE_W];
          bus.byte_valid <= 1'b1;
          bus.last_byte  <= 1'b0;
          state          <= ST_SEND;
        end
        ST_SEND: begin
          if (hand) begin
            shreg         <= shreg << BYTE_W;
            byte_idx      <= byte_idx + IDX_W'(1);
            bus.byte_out  <= shreg[BITS_WIDTH-BYTE_W-1 -: BYTE_W];
            bus.last_byte <= (byte_idx == LAST_IDX - IDX_W'(1));
            if (byte_idx == LAST_IDX) begin
              frame_count    <= frame_count + CNT_W'(1);
              bus.byte_valid <= 1'b0;
              bus.last_byte  <= 1'b0;
              state          <= fifo_empty ? ST_IDLE : ST_LOAD;
            end
          end
        end
        default: begin
          state          <= ST_IDLE;
          bus.byte_valid <= 1'b0;
        end
      endcase
    end
  end

  // Overflow tracking; a new drop outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= sat_inc(drop_count);
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_codec2_frame_packer.sv
// Directed self-checking bench for codec2_frame_packer.
module tb_codec2_frame_packer;
  import codec2_frame_packer_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear_overflow;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] drop_count;
  logic             overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] exp_b [0:35];
  int         stamp [0:35];
  frame_t     fr    [0:5];
  logic [7:0] t1_bytes [0:5];

  codec2_frame_packer_if bus();

  codec2_frame_packer dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .clear_overflow (clear_overflow),
    .frame_count    (frame_count),
    .drop_count     (drop_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input frame_t f);
    bus.frame_in    = f;
    bus.frame_valid = 1'b1;
    step();
    bus.frame_valid = 1'b0;
  endtask

  task automatic load_exp(input int base, input frame_t f);
    for (int k = 0; k < 6; k++) exp_b[base+k] = f[47-8*k -: 8];
  endtask

  // Accepts n bytes, optionally toggling byte_ready, checking data, last and hold stability.
  task automatic recv(input int n, input bit toggle);
    int         i = 0;
    int         guard = 0;
    bit         rdy = 1'b1;
    bit         holding = 1'b0;
    logic [7:0] held = '0;
    bit         held_last = 1'b0;
    while (i < n && guard < 500) begin
      if (holding) begin
        check("hold_valid", 64'(bus.byte_valid), 64'd1);
        check("hold_byte", 64'(bus.byte_out), 64'(held));
        check("hold_last", 64'(bus.last_byte), 64'(held_last));
        holding = 1'b0;
      end
      rdy = toggle ? ~rdy : 1'b1;
      bus.byte_ready = rdy;
      if (bus.byte_valid) begin
        if (rdy) begin
          check("byte", 64'(bus.byte_out), 64'(exp_b[i]));
          check("last", 64'(bus.last_byte), 64'((i % 6) == 5));
          stamp[i] = cyc;
          i++;
        end else begin
          held      = bus.byte_out;
          held_last = bus.last_byte;
          holding   = 1'b1;
        end
      end
      step();
      guard++;
    end
    bus.byte_ready = 1'b0;
    if (i < n) check("recv_timeout", 64'(i), 64'(n));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"},  64'(bus.byte_valid),  64'd0);
    check({tag, "_byte"},   64'(bus.byte_out),    64'd0);
    check({tag, "_last"},   64'(bus.last_byte),   64'd0);
    check({tag, "_ready"},  64'(bus.frame_ready), 64'd1);
    check({tag, "_fcount"}, 64'(frame_count),     64'd0);
    check({tag, "_dcount"}, 64'(drop_count),      64'd0);
    check({tag, "_ovf"},    64'(overflow),        64'd0);
  endtask

  initial begin
    rst             = 1'b0;
    clear_overflow  = 1'b0;
    bus.frame_in    = '0;
    bus.frame_valid = 1'b0;
    bus.byte_ready  = 1'b0;
    t1_bytes[0] = 8'h12; t1_bytes[1] = 8'h34; t1_bytes[2] = 8'h56;
    t1_bytes[3] = 8'h78; t1_bytes[4] = 8'h9A; t1_bytes[5] = 8'hBC;
    fr[0] = 48'hDEADBEEF0001; fr[1] = 48'hCAFEF00D0002; fr[2] = 48'h0123456789AB;
    fr[3] = 48'hFEDCBA987654; fr[4] = 48'h55AA55AA55AA; fr[5] = 48'hFFFFFFFFFFFF;

    repeat (2) step();
    check_reset_state("rst");
    rst = 1'b1;
    step();

    // 1: single frame, latency 3, one byte per cycle, last only on BC
    bus.byte_ready = 1'b1;
    push(48'h123456789ABC);
    for (int c = 1; c <= 9; c++) begin
      check("t1_valid", 64'(bus.byte_valid), 64'(c >= 3 && c <= 8));
      if (c >= 3 && c <= 8) begin
        check("t1_byte", 64'(bus.byte_out), 64'(t1_bytes[c-3]));
        check("t1_last", 64'(bus.last_byte), 64'(c == 8));
      end
      step();
    end
    check("t1_fcount", 64'(frame_count), 64'd1);
    bus.byte_ready = 1'b0;

    // 2: same frame with byte_ready toggling
    push(48'h123456789ABC);
    load_exp(0, 48'h123456789ABC);
    recv(6, 1'b1);
    step();
    check("t2_fcount", 64'(frame_count), 64'd2);
    check("t2_idle", 64'(bus.byte_valid), 64'd0);

    // 4: two frames back to back, single LOAD gap between them
    push(48'hA1B2C3D4E5F6);
    push(48'h0F1E2D3C4B5A);
    load_exp(0, 48'hA1B2C3D4E5F6);
    load_exp(6, 48'h0F1E2D3C4B5A);
    recv(12, 1'b0);
    check("t4_in_frame", 64'(stamp[5] - stamp[0]), 64'd5);
    check("t4_gap", 64'(stamp[6] - stamp[5]), 64'd2);
    step();
    check("t4_fcount", 64'(frame_count), 64'd4);

    // 3: stalled output; frame 0 sits in the shift register, frames 1-4 fill the FIFO
    for (int i = 0; i < 6; i++) begin
      if (i == 4) check("t3_ready_before5", 64'(bus.frame_ready), 64'd1);
      if (i == 5) check("t3_ready_full", 64'(bus.frame_ready), 64'd0);
      push(fr[i]);
    end
    check("t3_ovf", 64'(overflow), 64'd1);
    check("t3_drop", 64'(drop_count), 64'd1);
    check("t3_head", 64'(bus.byte_out), 64'h00000000000000DE);

    // 6: clear in the same cycle as a drop loses; clear alone wins
    bus.frame_in    = 48'hEEEEEEEEEEEE;
    bus.frame_valid = 1'b1;
    clear_overflow  = 1'b1;
    step();
    bus.frame_valid = 1'b0;
    check("t6_ovf_kept", 64'(overflow), 64'd1);
    check("t6_drop2", 64'(drop_count), 64'd2);
    step();
    clear_overflow = 1'b0;
    check("t6_ovf_clr", 64'(overflow), 64'd0);
    check("t6_drop_same", 64'(drop_count), 64'd2);

    for (int i = 0; i < 5; i++) load_exp(6*i, fr[i]);
    recv(30, 1'b0);
    step();
    check("t3_fcount", 64'(frame_count), 64'd9);
    check("t3_ready_after", 64'(bus.frame_ready), 64'd1);

    // 5: reset mid-frame, then a fresh frame starts from its MSB byte
    push(48'h0A0B0C0D0E0F);
    load_exp(0, 48'h0A0B0C0D0E0F);
    recv(3, 1'b0);
    rst = 1'b0;
    #1;
    check_reset_state("t5");
    step();
    check_reset_state("t5_hold");
    rst = 1'b1;
    step();
    check("t5_still_idle", 64'(bus.byte_valid), 64'd0);
    push(48'h778899AABBCC);
    load_exp(0, 48'h778899AABBCC);
    recv(6, 1'b0);
    step();
    check("t5_fcount", 64'(frame_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
